// File: rtl/hz_meter.sv
// ---- hz_meter : multi-channel gated rising-edge frequency meter ----
// ---- rev 1.0 ----
`default_nettype none
`timescale 1ns/1ps

module hz_meter #(
  parameter int CLK_HZ      = 100000000,
  parameter int GATE_CYCLES = 100000000,
  parameter int CHANNELS    = 1,
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       sig_in,
  input  logic [WIDTH-1:0]          band_lo,
  input  logic [WIDTH-1:0]          band_hi,
  output logic [CHANNELS*WIDTH-1:0] hz,
  output logic                      hz_valid,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       in_band,
  output logic                      gate_tick
);

  localparam int              GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  if (GATE_CYCLES < 4 || CHANNELS < 1 || CHANNELS > 8 || WIDTH < 1 ||
      SYNC_STAGES < 2 || CLK_HZ < 1) begin : g_param_check
    $error("hz_meter: illegal parameter set");
  end

  logic [GW-1:0] gate_cnt;

  // gate_tick already implies en, so it doubles as the window-close strobe
  assign gate_tick = en && (gate_cnt == GATE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
    end else if (!en || gate_tick) begin
      gate_cnt <= '0;
    end else begin
      gate_cnt <= gate_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_valid <= 1'b0;
    end else begin
      hz_valid <= gate_tick;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [WIDTH-1:0]       cnt_q;
    logic                   sticky_q;
    logic [WIDTH-1:0]       hz_q;
    logic                   ovf_q;
    logic                   in_band_q;
    logic                   rise;
    logic                   at_max;
    logic [WIDTH-1:0]       cnt_next;
    logic                   sticky_next;
    logic                   in_band_next;

    // prev_q resets low, so a line already high after reset counts once
    assign rise         = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign at_max       = (cnt_q == CNT_MAX);
    assign cnt_next     = (rise && !at_max) ? cnt_q + 1'b1 : cnt_q;
    assign sticky_next  = sticky_q | (rise & at_max);
    assign in_band_next = (cnt_next >= band_lo) && (cnt_next <= band_hi);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
        prev_q <= sync_q[SYNC_STAGES-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else if (!en || gate_tick) begin
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_next;
        sticky_q <= sticky_next;
      end
    end

    // Capture uses cnt_next so an edge in the closing cycle lands in this window
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hz_q      <= '0;
        ovf_q     <= 1'b0;
        in_band_q <= 1'b0;
      end else if (gate_tick) begin
        hz_q      <= cnt_next;
        ovf_q     <= sticky_next;
        in_band_q <= in_band_next;
      end
    end

    assign hz[i*WIDTH +: WIDTH] = hz_q;
    assign ovf[i]               = ovf_q;
    assign in_band[i]           = in_band_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_hz_meter.sv
// ---- tb_hz_meter : directed self-checking bench for hz_meter ----
// ---- rev 1.0 ----
`default_nettype none
`timescale 1ns/1ps

module tb_hz_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  sig_in;
  logic [9:0]  band_lo;
  logic [9:0]  band_hi;
  logic [19:0] hz;
  logic        hz_valid;
  logic [1:0]  ovf;
  logic [1:0]  in_band;
  logic        gate_tick;

  logic        sig4;
  logic [3:0]  band_lo4;
  logic [3:0]  band_hi4;
  logic [3:0]  hz4;
  logic        hz_valid4;
  logic        ovf4;
  logic        in_band4;
  logic        gate_tick4;

  int          per[3];
  int          ph[3];
  logic [2:0]  gen;
  logic [1:0]  man_mode;
  logic [1:0]  man_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hz_meter #(.CLK_HZ(100000000), .GATE_CYCLES(100), .CHANNELS(2), .WIDTH(10), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .band_lo(band_lo), .band_hi(band_hi),
    .hz(hz), .hz_valid(hz_valid), .ovf(ovf), .in_band(in_band), .gate_tick(gate_tick)
  );

  hz_meter #(.CLK_HZ(100000000), .GATE_CYCLES(100), .CHANNELS(1), .WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig4), .band_lo(band_lo4), .band_hi(band_hi4),
    .hz(hz4), .hz_valid(hz_valid4), .ovf(ovf4), .in_band(in_band4), .gate_tick(gate_tick4)
  );

  // Square-wave sources: period 0 holds the line low and rewinds the phase
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (per[c] == 0) begin
        gen[c] <= 1'b0;
        ph[c]  <= 0;
      end else begin
        gen[c] <= (ph[c] < per[c] / 2);
        ph[c]  <= (ph[c] + 1 >= per[c]) ? 0 : ph[c] + 1;
      end
    end
  end

  assign sig_in[0] = man_mode[0] ? man_val[0] : gen[0];
  assign sig_in[1] = man_mode[1] ? man_val[1] : gen[1];
  assign sig4      = gen[2];
  assign band_lo4  = 4'd0;
  assign band_hi4  = 4'd15;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the number of negedges until hz_valid is seen
  task automatic wait_valid(input string tag, output int n);
    n = 1;
    @(negedge clk);
    while (!hz_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!hz_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int w1;
    logic seen;
    rst_n    = 1'b0;
    en       = 1'b0;
    band_lo  = 10'd8;
    band_hi  = 10'd12;
    man_mode = 2'b00;
    man_val  = 2'b00;
    per      = '{10, 25, 4};
    cycles(3);

    check("rst_hz",        hz,        32'd0);
    check("rst_hz_valid",  hz_valid,  32'd0);
    check("rst_ovf",       ovf,       32'd0);
    check("rst_in_band",   in_band,   32'd0);
    check("rst_gate_tick", gate_tick, 32'd0);

    rst_n = 1'b1;
    en    = 1'b1;
    wait_valid("w1", n);
    wait_valid("w2", n);
    check("valid_gap",   n,       32'd100);
    check("hz_w2",       hz,      {12'd0, 10'd4, 10'd10});
    check("ovf_w2",      ovf,     32'd0);
    check("in_band_w2",  in_band, 32'b01);
    check("hz4_sat",     hz4,     32'd15);
    check("ovf4_sat",    ovf4,    32'd1);

    // Band change mid-window must not disturb the held results
    per[2] = 20;
    cycles(50);
    band_lo = 10'd13;
    band_hi = 10'd12;
    cycles(1);
    check("band_hold_in_band", in_band, 32'b01);
    check("band_hold_hz",      hz,      {12'd0, 10'd4, 10'd10});
    wait_valid("w3", n);
    check("band_inverted", in_band, 32'b00);
    check("hz_w3",         hz,      {12'd0, 10'd4, 10'd10});

    man_mode = 2'b10;
    man_val  = 2'b00;
    wait_valid("w4", n);
    check("hz4_unsat",   hz4,       32'd5);
    check("ovf4_unsat",  ovf4,      32'd0);
    check("valid4",      hz_valid4, 32'd1);
    check("in_band4",    in_band4,  32'd1);

    // ch1 pulses; the one driven at k=97 is detected on the closing edge
    w1 = 0;
    for (int k = 0; k <= 200; k++) begin
      case (k)
        10, 30, 97, 120, 150: man_val[1] = 1'b1;
        13, 33, 100, 123, 153: man_val[1] = 1'b0;
        default: ;
      endcase
      if (k == 99) begin
        check("tick_at_close",  gate_tick,  32'd1);
        check("tick4_at_close", gate_tick4, 32'd1);
      end
      if (k == 100) begin
        check("close_valid",   hz_valid,  32'd1);
        check("hz1_close_win", hz[19:10], 32'd3);
        w1 = int'(hz[19:10]);
      end
      if (k == 200) begin
        check("hz1_next_win", hz[19:10],             32'd2);
        check("hz1_sum",      w1 + int'(hz[19:10]),  32'd5);
      end
      if (k < 200) @(negedge clk);
    end

    // Enable drop mid-window
    band_lo = 10'd8;
    band_hi = 10'd12;
    cycles(40);
    en   = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      if (hz_valid) seen = 1'b1;
    end
    check("en_low_no_valid", seen, 32'd0);
    check("en_low_hz_hold",  hz,   {12'd0, 10'd2, 10'd10});
    en  = 1'b1;
    cyc = 1;  // the cycle in which en rises is cycle 1
    while (!hz_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("en_to_valid",      cyc,     32'd101);
    check("hz_after_en",      hz,      {12'd0, 10'd0, 10'd10});
    check("in_band_after_en", in_band, 32'b01);

    // Reset at gate count 50 with partial counts on both channels
    cycles(10);
    man_val[1] = 1'b1; cycles(3);
    man_val[1] = 1'b0; cycles(3);
    man_val[1] = 1'b1; cycles(3);
    man_val[1] = 1'b0; cycles(31);
    per[0] = 0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_hz",        hz,        32'd0);
    check("async_rst_hz_valid",  hz_valid,  32'd0);
    check("async_rst_ovf",       ovf,       32'd0);
    check("async_rst_in_band",   in_band,   32'd0);
    check("async_rst_gate_tick", gate_tick, 32'd0);
    check("async_rst_hz4",       hz4,       32'd0);
    cycles(3);
    rst_n  = 1'b1;
    per[0] = 10;
    cyc    = 1;
    while (!hz_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_to_valid", cyc, 32'd101);
    check("hz_after_rst", hz,  {12'd0, 10'd0, 10'd10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hz_meter.md
Name: hz_meter

Overview:
- Parametrised multi-channel frequency meter for the mic signal path.
- Counts rising edges of up to CHANNELS asynchronous square-wave inputs over a programmable gate window (default one second at 100 MHz).
- At each gate end it publishes a registered per-channel count with a one-cycle valid strobe and a per-channel tone-band flag.
- It generates its own gate internally, so there is no external one-second pulse. Downstream tone-detection and steering logic reads it directly.

Parameters:
- CLK_HZ, 100000000: system clock frequency; documentation only, not used in logic.
- GATE_CYCLES, 100000000: gate window length in clk cycles; must be >= 4.
- CHANNELS, 1: number of independent input channels, 1..8.
- WIDTH, 10: count and result width per channel.
- SYNC_STAGES, 2: synchronizer flops per input, >= 2.

Ports:
- clk  input  1  100 MHz system clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable.
- sig_in  input  CHANNELS  raw asynchronous mic-comparator inputs (e.g. JA1).
- band_lo  input  WIDTH  lower in-band bound, inclusive, shared by all channels.
- band_hi  input  WIDTH  upper in-band bound, inclusive.
- hz  output  CHANNELS*WIDTH  last completed count; channel n occupies bits [n*WIDTH +: WIDTH].
- hz_valid  output  1  one-cycle pulse when hz updates.
- ovf  output  CHANNELS  channel saturated during the last window.
- in_band  output  CHANNELS  band_lo <= hz[n] <= band_hi.
- gate_tick  output  1  one-cycle pulse on the last cycle of each window.

Behaviour:
- Reset (rst_n low, asynchronous): all synchronizer flops, edge-history flops, gate counter and edge counters go to 0. Outputs hz, hz_valid, ovf, in_band and gate_tick are all 0. Reset asserted mid-window discards the partial window; no update is produced.
- Synchronizer: each sig_in bit passes through SYNC_STAGES flops. A rising edge is detected when the synchronized value is 1 and the previous synchronized value was 0.
  - Input-to-detect latency is SYNC_STAGES+1 cycles.
  - An input already high at reset release is counted as one rising edge.
- Gate counter: counts 0..GATE_CYCLES-1 while en=1, then wraps to 0. gate_tick is combinationally high while the counter equals GATE_CYCLES-1.
- Edge counters: each channel increments by 1 per detected edge while en=1.
  - The counter saturates at 2^WIDTH-1 and sets a sticky per-window overflow bit.
  - No wrap-around is permitted.
- Window close (gate_tick=1 and en=1), all channels simultaneously:
  - Captured value is the count including any edge detected in that same cycle, with saturation applied.
  - The capture goes to hz[n] on the next clk edge. ovf[n] takes the sticky bit.
  - in_band[n] is computed from the captured value and the current band_lo/band_hi, and registered on the same edge.
  - hz_valid is high for exactly the one cycle after the close edge, coincident with the new hz.
  - Edge counters and sticky overflow bits clear to 0. An edge in the close cycle is not also counted in the next window.
- Result registers hold between closes. hz and in_band do not change when band_lo/band_hi change mid-window; the comparison uses the bounds sampled at close.
- If band_lo > band_hi, every in_band bit is 0.
- en=0: gate counter and edge counters clear and hold at 0. No gate_tick and no hz_valid are produced. hz, ovf and in_band hold their last values. The first window after en rises is a full GATE_CYCLES cycles long.
- Arithmetic is unsigned throughout. Maximum measurable frequency is (2^WIDTH-1) edges per window. Input pulses shorter than one clk period may be missed; this is out of scope.

Test Plan:
- GATE_CYCLES=100, CHANNELS=2, WIDTH=10; ch0 square wave with period 10 cycles, ch1 period 25 cycles -> after the second gate_tick, hz = {ch1=4, ch0=10}, hz_valid pulses exactly once per 100 cycles, ovf=0.
- WIDTH=4, ch0 period 4 cycles (25 edges/window) -> hz[0]=15, ovf[0]=1. Then set period 20 cycles -> the next window gives hz[0]=5, ovf[0]=0.
- band_lo=8, band_hi=12, ch0 at 10 edges and ch1 at 4 edges -> in_band=2'b01. Set band_lo=13, band_hi=12 -> the next update gives in_band=2'b00.
- Force a synchronized edge in the cycle where gate_tick=1 -> it is counted in the closing window only. The sum of hz over consecutive windows equals the total edges driven.
- en driven low for 37 cycles mid-window, then high -> no hz_valid during the low period and hz holds. The next hz_valid occurs exactly 101 cycles after en rises (100-cycle window plus 1).
- rst_n pulsed low for 3 cycles at count 50 -> all outputs 0 immediately, asynchronously. The first hz_valid occurs 101 cycles after rst_n rises, with a count of the post-reset edges only.
